// File: rtl/insn_profiler_pkg.sv
// Shared opcode constants, instruction class and FSM state types for the
// instruction profiler.
package insn_profiler_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_BLEZ  = 6'h06;
    localparam logic [5:0] OP_BGTZ  = 6'h07;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef enum logic [1:0] {
        CLS_NONE,
        CLS_R,
        CLS_I,
        CLS_J
    } insn_class_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_e;

endpackage

// File: rtl/insn_profiler_decode.sv
// Combinational MIPS word classifier. With INSN_PROFILER_WB_FILTER_EN defined,
// branches and stores keep their I-type class but report no destination.
module insn_decode
    import insn_profiler_pkg::*;
(
    input  logic [31:0]  word,
    output insn_class_e  cls,
    output logic         dest_valid,
    output logic [4:0]   dest
);

    // Source fields and immediates play no part in classification.
    logic unused_fields;
    assign unused_fields = ^{word[25:21], word[10:0]};

    always_comb begin
        cls        = CLS_I;
        dest_valid = 1'b1;
        dest       = word[20:16];
        case (word[31:26])
            OP_RTYPE: begin
                cls  = CLS_R;
                dest = word[15:11];
            end
            OP_J, OP_JAL: begin
                cls        = CLS_J;
                dest_valid = 1'b0;
            end
`ifdef INSN_PROFILER_WB_FILTER_EN
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_SB, OP_SH, OP_SW: begin
                dest_valid = 1'b0;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/insn_profiler.sv
// Instruction-mix profiler: loads MIPS words, then counts R/I/J classes and
// writes to a window of destination registers. Optional macro: INSN_PROFILER_WB_FILTER_EN.
module insn_profiler
    import insn_profiler_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int CNT_W      = 8,
    parameter int NTRACK     = 4,
    parameter int TRACK_BASE = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [$clog2(DEPTH+1)-1:0] len,
    input  logic                       wr_en,
    input  logic [$clog2(DEPTH)-1:0]   wr_addr,
    input  logic [31:0]                wr_data,
    output logic                       busy,
    output logic                       done,
    output logic [CNT_W-1:0]           icount,
    output logic [CNT_W-1:0]           rcount,
    output logic [CNT_W-1:0]           jcount,
    output logic [NTRACK*CNT_W-1:0]    reg_count,
    output logic                       overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    typedef logic [CNT_W-1:0] cnt_t;

    logic [31:0]   mem [DEPTH];
    state_e        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [LW-1:0] len_q, len_d;
    cnt_t          icnt_q, icnt_d, rcnt_q, rcnt_d, jcnt_q, jcnt_d;
    cnt_t          reg_cnt_q [NTRACK];
    cnt_t          reg_cnt_d [NTRACK];
    logic          ovf_q, ovf_d;

    insn_class_e   cls;
    logic          dest_valid;
    logic [4:0]    dest;
    logic [LW-1:0] len_eff;
    logic          last_word;
    logic          accept_start;

    insn_decode u_decode (
        .word       (mem[ptr_q]),
        .cls        (cls),
        .dest_valid (dest_valid),
        .dest       (dest)
    );

    assign len_eff      = (len > LW'(DEPTH)) ? LW'(DEPTH) : len;
    assign last_word    = (LW'(ptr_q) + LW'(1)) == len_q;
    assign accept_start = start && (state_q != ST_RUN);

    function automatic cnt_t sat_inc(input cnt_t v);
        return (v == '1) ? v : v + cnt_t'(1);
    endfunction

    // Memory is deliberately outside the reset domain so programs survive rst_n.
    always_ff @(posedge clk) begin
        if (wr_en && state_q != ST_RUN) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            len_q   <= '0;
            icnt_q  <= '0;
            rcnt_q  <= '0;
            jcnt_q  <= '0;
            ovf_q   <= 1'b0;
            for (int k = 0; k < NTRACK; k++) begin
                reg_cnt_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            len_q   <= len_d;
            icnt_q  <= icnt_d;
            rcnt_q  <= rcnt_d;
            jcnt_q  <= jcnt_d;
            ovf_q   <= ovf_d;
            for (int k = 0; k < NTRACK; k++) begin
                reg_cnt_q[k] <= reg_cnt_d[k];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: if (start) state_d = (len_eff != '0) ? ST_RUN : ST_DONE;
            ST_RUN:           if (last_word) state_d = ST_DONE;
            default:          state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ptr_d  = ptr_q;
        len_d  = len_q;
        icnt_d = icnt_q;
        rcnt_d = rcnt_q;
        jcnt_d = jcnt_q;
        ovf_d  = ovf_q;
        for (int k = 0; k < NTRACK; k++) begin
            reg_cnt_d[k] = reg_cnt_q[k];
        end
        if (accept_start) begin
            ptr_d  = '0;
            len_d  = len_eff;
            icnt_d = '0;
            rcnt_d = '0;
            jcnt_d = '0;
            ovf_d  = 1'b0;
            for (int k = 0; k < NTRACK; k++) begin
                reg_cnt_d[k] = '0;
            end
        end else if (state_q == ST_RUN) begin
            ptr_d = ptr_q + AW'(1);
            case (cls)
                CLS_R: begin rcnt_d = sat_inc(rcnt_q); ovf_d = ovf_d | (rcnt_q == '1); end
                CLS_I: begin icnt_d = sat_inc(icnt_q); ovf_d = ovf_d | (icnt_q == '1); end
                CLS_J: begin jcnt_d = sat_inc(jcnt_q); ovf_d = ovf_d | (jcnt_q == '1); end
                default: ;
            endcase
            for (int k = 0; k < NTRACK; k++) begin
                if (dest_valid && dest == 5'(TRACK_BASE + k)) begin
                    reg_cnt_d[k] = sat_inc(reg_cnt_q[k]);
                    ovf_d        = ovf_d | (reg_cnt_q[k] == '1);
                end
            end
        end
    end

    always_comb begin
        busy = (state_q == ST_RUN);
        done = (state_q == ST_DONE);
    end

    assign icount   = icnt_q;
    assign rcount   = rcnt_q;
    assign jcount   = jcnt_q;
    assign overflow = ovf_q;

    generate
        for (genvar gi = 0; gi < NTRACK; gi++) begin : g_reg_out
            assign reg_count[gi*CNT_W +: CNT_W] = reg_cnt_q[gi];
        end
    endgenerate

endmodule

// File: tb/tb_insn_profiler.sv
// Randomized self-checking bench for insn_profiler against a counting model;
// a second instance with CNT_W=2 exercises saturation.
module tb_insn_profiler;

    localparam int DEPTH      = 8;
    localparam int CNT_W      = 8;
    localparam int NTRACK     = 4;
    localparam int TRACK_BASE = 3;
    localparam int CW2        = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start, wr_en, busy, done, overflow;
    logic [3:0]  len;
    logic [2:0]  wr_addr;
    logic [31:0] wr_data;
    logic [CNT_W-1:0] icount, rcount, jcount;
    logic [NTRACK*CNT_W-1:0] reg_count;

    logic        start_b, wr_en_b, busy_b, done_b, overflow_b;
    logic [3:0]  len_b;
    logic [2:0]  wr_addr_b;
    logic [31:0] wr_data_b;
    logic [CW2-1:0] icount_b, rcount_b, jcount_b;
    logic [NTRACK*CW2-1:0] reg_count_b;

    insn_profiler #(.DEPTH(DEPTH), .CNT_W(CNT_W), .NTRACK(NTRACK), .TRACK_BASE(TRACK_BASE)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done),
        .icount(icount), .rcount(rcount), .jcount(jcount),
        .reg_count(reg_count), .overflow(overflow)
    );

    insn_profiler #(.DEPTH(DEPTH), .CNT_W(CW2), .NTRACK(NTRACK), .TRACK_BASE(TRACK_BASE)) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(start_b), .len(len_b), .wr_en(wr_en_b),
        .wr_addr(wr_addr_b), .wr_data(wr_data_b), .busy(busy_b), .done(done_b),
        .icount(icount_b), .rcount(rcount_b), .jcount(jcount_b),
        .reg_count(reg_count_b), .overflow(overflow_b)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    endtask

    // Reference model: program image plus expected results of a run.
    logic [31:0] mdl_mem [DEPTH];
    int exp_i, exp_r, exp_j, exp_lat;
    int exp_reg [NTRACK];
    bit exp_ov;

    function automatic int sat(input int raw, input int maxv);
        return (raw > maxv) ? maxv : raw;
    endfunction

    task automatic model_run(input int l);
        int n, maxv, raw_i, raw_r, raw_j, dst;
        int raw_reg [NTRACK];
        bit has;
        logic [31:0] w;
        logic [5:0]  op;
        n = (l > DEPTH) ? DEPTH : l;
        maxv = (1 << CNT_W) - 1;
        raw_i = 0; raw_r = 0; raw_j = 0;
        for (int k = 0; k < NTRACK; k++) raw_reg[k] = 0;
        for (int a = 0; a < n; a++) begin
            w = mdl_mem[a];
            op = w[31:26];
            has = 1'b0;
            dst = 0;
            if (op == 6'h00) begin
                raw_r++; has = 1'b1; dst = int'(w[15:11]);
            end else if (op == 6'h02 || op == 6'h03) begin
                raw_j++;
            end else begin
                raw_i++; has = 1'b1; dst = int'(w[20:16]);
`ifdef INSN_PROFILER_WB_FILTER_EN
                if (op inside {6'h04, 6'h05, 6'h06, 6'h07, 6'h28, 6'h29, 6'h2B}) has = 1'b0;
`endif
            end
            if (has && dst >= TRACK_BASE && dst < TRACK_BASE + NTRACK) raw_reg[dst-TRACK_BASE]++;
        end
        exp_i = sat(raw_i, maxv);
        exp_r = sat(raw_r, maxv);
        exp_j = sat(raw_j, maxv);
        exp_ov = (raw_i > maxv) || (raw_r > maxv) || (raw_j > maxv);
        for (int k = 0; k < NTRACK; k++) begin
            exp_reg[k] = sat(raw_reg[k], maxv);
            if (raw_reg[k] > maxv) exp_ov = 1'b1;
        end
        exp_lat = n;
    endtask

    task automatic check_results(input string ctx);
        check({ctx, " icount"}, 64'(icount), 64'(exp_i));
        check({ctx, " rcount"}, 64'(rcount), 64'(exp_r));
        check({ctx, " jcount"}, 64'(jcount), 64'(exp_j));
        for (int k = 0; k < NTRACK; k++)
            check($sformatf("%s reg%0d", ctx, TRACK_BASE + k),
                  64'(reg_count[k*CNT_W +: CNT_W]), 64'(exp_reg[k]));
        check({ctx, " overflow"}, 64'(overflow), 64'(exp_ov));
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = 3'(a); wr_data = d;
        @(posedge clk); #1;
        wr_en = 1'b0;
        mdl_mem[a] = d;
    endtask

    // Edges after the start-sampling edge until done is seen (bounded).
    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run(input int l, output int lat, output logic busy0);
        start = 1'b1; len = 4'(l);
        @(posedge clk); #1;
        start = 1'b0;
        busy0 = busy;
        wait_done(lat);
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        logic [5:0] ops [10];
        ops = '{6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h23, 6'h2B, 6'h0D};
        w = $urandom;
        w[31:26] = ops[$urandom_range(0, 9)];
        w[20:16] = 5'($urandom_range(2, 7));
        w[15:11] = 5'($urandom_range(2, 7));
        return w;
    endfunction

    logic [31:0] prog [8] = '{32'h20043456, 32'h2005FFFF, 32'h00A43020, 32'h20030007,
                              32'h00C33004, 32'h00031842, 32'h8C859ABC, 32'h08123456};

    initial begin
        int lat, l;
        logic busy0;

        rst_n = 1'b0; start = 1'b0; len = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        start_b = 1'b0; len_b = '0; wr_en_b = 1'b0; wr_addr_b = '0; wr_data_b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", 64'(busy), 64'(0));
        check("reset done", 64'(done), 64'(0));
        check("reset counters", 64'({icount, rcount, jcount, reg_count}), 64'(0));
        check("reset overflow", 64'(overflow), 64'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Saturation on the narrow-counter instance.
        for (int a = 0; a < DEPTH; a++) begin
            wr_en_b = 1'b1; wr_addr_b = 3'(a); wr_data_b = 32'h00031820;
            @(posedge clk); #1;
        end
        wr_en_b = 1'b0;
        start_b = 1'b1; len_b = 4'd8;
        @(posedge clk); #1;
        start_b = 1'b0;
        lat = 0;
        while (!done_b && lat < 40) begin @(posedge clk); #1; lat++; end
        check("sat latency", 64'(lat), 64'(8));
        check("sat rcount", 64'(rcount_b), 64'(3));
        check("sat reg3", 64'(reg_count_b[1:0]), 64'(3));
        check("sat icount", 64'(icount_b), 64'(0));
        check("sat overflow", 64'(overflow_b), 64'(1));

        // Reference program.
        for (int a = 0; a < 8; a++) wr(a, prog[a]);
        model_run(8);
        run(8, lat, busy0);
        check("prog busy", 64'(busy0), 64'(1));
        check("prog latency", 64'(lat), 64'(8));
        check_results("prog");
        check("prog icount const", 64'(icount), 64'(4));
        repeat (2) @(posedge clk);
        #1;
        check("prog done held", 64'(done), 64'(1));
        check_results("prog held");

        // Write attempted during a run is ignored.
        start = 1'b1; len = 4'd8;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = 32'h08000000;
        @(posedge clk); #1;
        wr_en = 1'b0;
        wait_done(lat);
        check("runwr done", 64'(done), 64'(1));
        check_results("runwr");
        model_run(1);
        run(1, lat, busy0);
        check_results("runwr word0");

        // Zero-length run, then a short run that must re-clear.
        run(0, lat, busy0);
        check("len0 busy", 64'(busy0), 64'(0));
        check("len0 done one cycle after start", 64'(lat), 64'(0));
        check("len0 counters", 64'({icount, rcount, jcount, reg_count, overflow}), 64'(0));
        model_run(3);
        run(3, lat, busy0);
        check("len3 latency", 64'(lat), 64'(3));
        check_results("len3");

        // Reset in the middle of a run.
        start = 1'b1; len = 4'd8;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst busy", 64'(busy), 64'(0));
        check("midrst done", 64'(done), 64'(0));
        check("midrst counters", 64'({icount, rcount, jcount, reg_count, overflow}), 64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("midrst no done", 64'(done), 64'(0));
        model_run(8);
        run(8, lat, busy0);
        check("midrst rerun latency", 64'(lat), 64'(8));
        check_results("midrst rerun");

        // Randomized programs and lengths, including len > DEPTH.
        for (int it = 0; it < 24; it++) begin
            int nw;
            nw = $urandom_range(1, 4);
            for (int j = 0; j < nw; j++) wr($urandom_range(0, DEPTH - 1), rand_word());
            l = $urandom_range(0, 12);
            model_run(l);
            run(l, lat, busy0);
            $display("rand %0d: len=%0d lat=%0d i=%0d r=%0d j=%0d ovf=%0d", it, l, lat, icount, rcount, jcount, overflow);
            check($sformatf("rand%0d busy", it), 64'(busy0), 64'(exp_lat != 0));
            check($sformatf("rand%0d latency", it), 64'(lat), 64'(exp_lat));
            check_results($sformatf("rand%0d", it));
        end

        // Branch destination filtering.
        wr(0, 32'h10040000);
        model_run(1);
        run(1, lat, busy0);
        check_results("beq");
`ifdef INSN_PROFILER_WB_FILTER_EN
        check("beq reg4 const", 64'(reg_count[CNT_W +: CNT_W]), 64'(0));
`else
        check("beq reg4 const", 64'(reg_count[CNT_W +: CNT_W]), 64'(1));
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
